instr_cycle_sequencer: RTL and testbench

//  Multi-cycle instruction sequencer for the RISCY core. It steps each instruction

---
 rtl/instr_cycle_sequencer_pkg.sv | 26 ++
 rtl/instr_cycle_sequencer_mem_wait_timer.sv | 30 +++
 rtl/instr_cycle_sequencer.sv | 147 ++++++++++++++
 tb/tb_instr_cycle_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_cycle_sequencer_pkg.sv
// Shared state encoding and opcode constants for the multi-cycle instruction sequencer.
package instr_cycle_sequencer_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6,
      S_ERR    = 3'd7
   } seq_state_t;

   localparam logic [3:0] OP_NOP    = 4'h0;
   localparam logic [3:0] OP_LOAD   = 4'h8;
   localparam logic [3:0] OP_STORE  = 4'h9;
   localparam logic [3:0] OP_BRANCH = 4'hA;
   localparam logic [3:0] OP_HALT   = 4'hF;

   // FETCH and MEM are the only states that drive a memory request.
   function automatic logic is_req_state(input seq_state_t s);
      return (s == S_FETCH) || (s == S_MEM);
   endfunction

endpackage

// File: rtl/instr_cycle_sequencer_mem_wait_timer.sv
// Counts unacknowledged request cycles; expired is combinational and fires on the
// waiting cycle that brings the count to limit.
module mem_wait_timer #(
   parameter int W = 4
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         enable,
   input  logic         clear,
   input  logic [W-1:0] limit,
   output logic         expired
);

   logic [W-1:0] cnt;
   logic [W-1:0] cnt_inc;

   assign cnt_inc = cnt + W'(1);
   assign expired = enable && (cnt_inc >= limit);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= cnt_inc;
      end
   end

endmodule

// File: rtl/instr_cycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/[MEM]/WB sequencer with per-phase datapath strobes.
// ALU ops take 4 cycles, LOAD/STORE 5, plus one per memory wait cycle.
module instr_cycle_sequencer
   import instr_cycle_sequencer_pkg::*;
#(
   parameter int OPC_W   = 4,
   parameter int CNT_W   = 16,
   parameter int MEM_TMO = 15
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic             HALT_REQ,
   input  logic [OPC_W-1:0] OPCODE,
   input  logic             MEM_ACK,
   output logic             MEM_REQ,
   output logic             MEM_WE,
   output logic             IR_LD,
   output logic             PC_INC,
   output logic             ALU_GO,
   output logic             REG_WE,
   output logic             RETIRE,
   output logic [2:0]       STATE,
   output logic             BUSY,
   output logic             ERR,
   output logic [CNT_W-1:0] INSTR_CNT
);

   localparam int TMR_W = $clog2(MEM_TMO + 1);

   seq_state_t       state;
   seq_state_t       state_nxt;
   logic             mem_req;
   logic             mem_we;
   logic             ir_ld;
   logic             alu_go;
   logic             reg_we;
   logic             retire;
   logic             tmr_en;
   logic             tmr_clr;
   logic             tmr_exp;
   logic [CNT_W-1:0] instr_cnt;

   logic is_load, is_store, is_branch, is_nop, is_halt;

   assign is_load   = (OPCODE == OPC_W'(OP_LOAD));
   assign is_store  = (OPCODE == OPC_W'(OP_STORE));
   assign is_branch = (OPCODE == OPC_W'(OP_BRANCH));
   assign is_nop    = (OPCODE == OPC_W'(OP_NOP));
   assign is_halt   = (OPCODE == OPC_W'(OP_HALT));

   // Timer only runs while a request is outstanding; it restarts for every access.
   assign tmr_en  = mem_req && !MEM_ACK;
   assign tmr_clr = MEM_ACK || !is_req_state(state_nxt);

   mem_wait_timer #(
      .W(TMR_W)
   ) u_mem_wait_timer (
      .CLK     (CLK),
      .RST     (RST),
      .enable  (tmr_en),
      .clear   (tmr_clr),
      .limit   (TMR_W'(MEM_TMO)),
      .expired (tmr_exp)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      ir_ld     = 1'b0;
      alu_go    = 1'b0;
      reg_we    = 1'b0;
      retire    = 1'b0;
      case (state)
         S_IDLE, S_HALT: begin
            if (START) state_nxt = S_FETCH;
         end
         S_FETCH: begin
            mem_req = 1'b1;
            // An ACK on the expiry cycle still completes the access.
            if (MEM_ACK) begin
               ir_ld     = 1'b1;
               state_nxt = S_DECODE;
            end else if (tmr_exp) begin
               state_nxt = S_ERR;
            end
         end
         S_DECODE: begin
            state_nxt = S_EXEC;
         end
         S_EXEC: begin
            alu_go    = 1'b1;
            state_nxt = (is_load || is_store) ? S_MEM : S_WB;
         end
         S_MEM: begin
            mem_req = 1'b1;
            mem_we  = is_store;
            if (MEM_ACK) begin
               state_nxt = S_WB;
            end else if (tmr_exp) begin
               state_nxt = S_ERR;
            end
         end
         S_WB: begin
            retire    = 1'b1;
            reg_we    = !(is_store || is_branch || is_nop);
            state_nxt = (is_halt || HALT_REQ) ? S_HALT : S_FETCH;
         end
         S_ERR: begin
            state_nxt = S_ERR;
         end
         default: begin
            state_nxt = S_ERR;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         instr_cnt <= '0;
      end else if (retire) begin
         instr_cnt <= instr_cnt + CNT_W'(1);
      end
   end

   assign MEM_REQ   = mem_req;
   assign MEM_WE    = mem_we;
   assign IR_LD     = ir_ld;
   assign PC_INC    = ir_ld;
   assign ALU_GO    = alu_go;
   assign REG_WE    = reg_we;
   assign RETIRE    = retire;
   assign STATE     = state;
   assign BUSY      = !((state == S_IDLE) || (state == S_HALT) || (state == S_ERR));
   assign ERR       = (state == S_ERR);
   assign INSTR_CNT = instr_cnt;

endmodule

// File: tb/tb_instr_cycle_sequencer.sv
// Directed bench for instr_cycle_sequencer; retirements are checked against a scoreboard
// filled as each instruction is driven.
module tb_instr_cycle_sequencer;
   import instr_cycle_sequencer_pkg::*;

   localparam int OPC_W   = 4;
   localparam int CNT_W   = 4;
   localparam int MEM_TMO = 15;

   logic             CLK;
   logic             RST;
   logic             START;
   logic             HALT_REQ;
   logic [OPC_W-1:0] OPCODE;
   logic             MEM_ACK;
   logic             MEM_REQ;
   logic             MEM_WE;
   logic             IR_LD;
   logic             PC_INC;
   logic             ALU_GO;
   logic             REG_WE;
   logic             RETIRE;
   logic [2:0]       STATE;
   logic             BUSY;
   logic             ERR;
   logic [CNT_W-1:0] INSTR_CNT;

   typedef struct {
      logic             reg_we;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   exp_t             sb_q[$];
   logic [CNT_W-1:0] exp_cnt;
   int               n_tests;
   int               n_fail;

   instr_cycle_sequencer #(
      .OPC_W   (OPC_W),
      .CNT_W   (CNT_W),
      .MEM_TMO (MEM_TMO)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .START     (START),
      .HALT_REQ  (HALT_REQ),
      .OPCODE    (OPCODE),
      .MEM_ACK   (MEM_ACK),
      .MEM_REQ   (MEM_REQ),
      .MEM_WE    (MEM_WE),
      .IR_LD     (IR_LD),
      .PC_INC    (PC_INC),
      .ALU_GO    (ALU_GO),
      .REG_WE    (REG_WE),
      .RETIRE    (RETIRE),
      .STATE     (STATE),
      .BUSY      (BUSY),
      .ERR       (ERR),
      .INSTR_CNT (INSTR_CNT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Scoreboard consumer: every WB cycle must match the oldest pushed instruction.
   always @(negedge CLK) begin
      if (RST && RETIRE) begin
         if (sb_q.size() == 0) begin
            check("sb_unexpected_retire", 32'(RETIRE), 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("sb_reg_we", 32'(REG_WE), 32'(e.reg_we));
            check("sb_cnt_at_wb", 32'(INSTR_CNT), 32'(e.cnt));
         end
      end
   end

   task automatic start_run();
      START = 1'b1;
      @(negedge CLK);
      check("start_not_busy", 32'(BUSY), 32'd0);
      tick();
      START = 1'b0;
      check("start_to_fetch", 32'(STATE), 32'(S_FETCH));
   endtask

   // Called with the DUT in FETCH, just after a rising edge.
   task automatic do_instr(input logic [3:0] op, input int fw, input int mw,
                           input logic halt_wb, input logic halt_fetch, input logic start_exec);
      exp_t e;
      logic mem_op;
      mem_op   = (op == 4'h8) || (op == 4'h9);
      OPCODE   = op;
      HALT_REQ = halt_fetch;
      for (int i = 0; i < fw; i++) begin
         @(negedge CLK);
         check("fetch_wait_state", 32'(STATE), 32'(S_FETCH));
         check("fetch_wait_req", 32'(MEM_REQ), 32'd1);
         check("fetch_wait_irld", 32'(IR_LD), 32'd0);
         tick();
      end
      MEM_ACK = 1'b1;
      @(negedge CLK);
      check("fetch_ack_state", 32'(STATE), 32'(S_FETCH));
      check("fetch_ir_ld", 32'(IR_LD), 32'd1);
      check("fetch_pc_inc", 32'(PC_INC), 32'd1);
      tick();
      MEM_ACK  = 1'b0;
      HALT_REQ = 1'b0;
      @(negedge CLK);
      check("decode_state", 32'(STATE), 32'(S_DECODE));
      check("decode_req", 32'(MEM_REQ), 32'd0);
      tick();
      START = start_exec;
      @(negedge CLK);
      check("exec_state", 32'(STATE), 32'(S_EXEC));
      check("exec_alu_go", 32'(ALU_GO), 32'd1);
      tick();
      START = 1'b0;
      if (mem_op) begin
         for (int i = 0; i < mw; i++) begin
            @(negedge CLK);
            check("mem_wait_state", 32'(STATE), 32'(S_MEM));
            check("mem_wait_req", 32'(MEM_REQ), 32'd1);
            check("mem_wait_we", 32'(MEM_WE), 32'(op == 4'h9));
            tick();
         end
         MEM_ACK = 1'b1;
         @(negedge CLK);
         check("mem_ack_state", 32'(STATE), 32'(S_MEM));
         check("mem_ack_we", 32'(MEM_WE), 32'(op == 4'h9));
         tick();
         MEM_ACK = 1'b0;
      end
      e.reg_we = !((op == 4'h9) || (op == 4'hA) || (op == 4'h0));
      e.cnt    = exp_cnt;
      sb_q.push_back(e);
      exp_cnt  = exp_cnt + 1'b1;
      HALT_REQ = halt_wb;
      @(negedge CLK);
      check("wb_state", 32'(STATE), 32'(S_WB));
      check("wb_alu_go", 32'(ALU_GO), 32'd0);
      tick();
      HALT_REQ = 1'b0;
      check("post_wb_state", 32'(STATE),
            ((op == 4'hF) || halt_wb) ? 32'(S_HALT) : 32'(S_FETCH));
      check("post_wb_cnt", 32'(INSTR_CNT), 32'(exp_cnt));
   endtask

   initial begin
      logic [3:0] ops [6];
      ops      = '{4'h1, 4'h8, 4'h9, 4'hA, 4'h0, 4'h5};
      n_tests  = 0;
      n_fail   = 0;
      exp_cnt  = '0;
      RST      = 1'b0;
      START    = 1'b0;
      HALT_REQ = 1'b0;
      MEM_ACK  = 1'b0;
      OPCODE   = '0;

      @(negedge CLK);
      check("rst_state", 32'(STATE), 32'(S_IDLE));
      check("rst_mem_req", 32'(MEM_REQ), 32'd0);
      check("rst_busy", 32'(BUSY), 32'd0);
      check("rst_err", 32'(ERR), 32'd0);
      check("rst_cnt", 32'(INSTR_CNT), 32'd0);
      check("rst_retire", 32'(RETIRE), 32'd0);
      tick();
      RST = 1'b1;
      tick();
      check("idle_hold", 32'(STATE), 32'(S_IDLE));

      // Plain ALU op, then LOAD, then STORE with a slow memory.
      start_run();
      do_instr(4'h1, 0, 0, 1'b0, 1'b0, 1'b0);
      do_instr(4'h8, 0, 0, 1'b0, 1'b0, 1'b0);
      do_instr(4'h9, 1, 3, 1'b0, 1'b0, 1'b0);

      // HALT_REQ only counts in WB.
      do_instr(4'h2, 4, 0, 1'b0, 1'b1, 1'b0);
      do_instr(4'h3, 0, 0, 1'b1, 1'b0, 1'b0);
      check("halt_busy", 32'(BUSY), 32'd0);
      tick();
      check("halt_hold", 32'(STATE), 32'(S_HALT));
      start_run();
      do_instr(4'hA, 2, 0, 1'b0, 1'b0, 1'b0);

      // HALT opcode retires then stops; START during EXEC is ignored.
      do_instr(4'hF, 0, 0, 1'b0, 1'b0, 1'b1);
      start_run();

      // Fetch timeout.
      OPCODE = 4'h1;
      for (int i = 0; i < MEM_TMO; i++) begin
         @(negedge CLK);
         check("tmo_wait_state", 32'(STATE), 32'(S_FETCH));
         check("tmo_wait_err", 32'(ERR), 32'd0);
         tick();
      end
      check("tmo_state", 32'(STATE), 32'(S_ERR));
      check("tmo_err", 32'(ERR), 32'd1);
      check("tmo_mem_req", 32'(MEM_REQ), 32'd0);
      check("tmo_busy", 32'(BUSY), 32'd0);
      START = 1'b1;
      tick();
      START = 1'b0;
      check("err_sticky", 32'(STATE), 32'(S_ERR));
      RST = 1'b0;
      #1;
      check("err_rst_cnt", 32'(INSTR_CNT), 32'd0);
      check("err_rst_err", 32'(ERR), 32'd0);
      tick();
      RST     = 1'b1;
      exp_cnt = '0;

      // ACK on the last allowed cycle wins over the timeout.
      start_run();
      do_instr(4'h4, MEM_TMO - 1, 0, 1'b0, 1'b0, 1'b0);
      check("late_ack_err", 32'(ERR), 32'd0);

      // Asynchronous reset in the middle of a MEM access.
      OPCODE  = 4'h8;
      MEM_ACK = 1'b1;
      tick();
      MEM_ACK = 1'b0;
      tick();
      tick();
      @(negedge CLK);
      check("pre_rst_mem_req", 32'(MEM_REQ), 32'd1);
      RST = 1'b0;
      #1;
      check("mid_rst_mem_req", 32'(MEM_REQ), 32'd0);
      check("mid_rst_state", 32'(STATE), 32'(S_IDLE));
      check("mid_rst_cnt", 32'(INSTR_CNT), 32'd0);
      tick();
      RST     = 1'b1;
      exp_cnt = '0;

      // Fill the counter to all-ones, then wrap.
      start_run();
      for (int i = 0; i < (1 << CNT_W) - 1; i++) begin
         do_instr(ops[i % 6], int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                  1'b0, 1'b0, 1'b0);
      end
      check("cnt_full", 32'(INSTR_CNT), 32'((1 << CNT_W) - 1));
      do_instr(4'h1, 0, 0, 1'b0, 1'b0, 1'b0);
      check("cnt_wrap", 32'(INSTR_CNT), 32'd0);

      tick();
      check("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog");
   end

endmodule
